// File: rtl/scalar_wb_queue_pkg.sv
// Datapath types shared by the scalar writeback queue.
// Contents: word/register types, execute-stage result bundle, register-file write bundle,
// queue entry type, queue sizing constants and a source-select helper.
package scalar_wb_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int unsigned WBQ_DEPTH  = 8;
  localparam int unsigned WBQ_MAX_IN = 3;

  // Execute-stage output latch: one result slot per scalar unit.
  typedef struct packed {
    logic     alu_done;
    logic     load_done;
    logic     jump_done;
    word_t    alu_wdat;
    word_t    load_wdat;
    word_t    jump_wdat;
    regbits_t alu_reg_sel;
    regbits_t load_reg_sel;
    regbits_t jump_reg_sel;
    logic     spec;
  } execute_t;

  typedef struct packed {
    logic     reg_en;
    regbits_t reg_sel;
    word_t    wdat;
  } wb_t;

  typedef struct packed {
    logic     valid;
    logic     spec;
    regbits_t rd;
    word_t    wdat;
  } wbq_entry_t;

  // Source index, also the fixed enqueue priority (jump first).
  typedef enum logic [1:0] {
    SrcJump = 2'd0,
    SrcLoad = 2'd1,
    SrcAlu  = 2'd2
  } wbq_src_e;

  // Pull rd/wdat of one unit out of the execute bundle; valid/spec left clear.
  function automatic wbq_entry_t wbq_pick(input execute_t ex, input logic [1:0] src);
    wbq_entry_t e;
    e = '0;
    case (src)
      SrcJump: begin
        e.rd   = ex.jump_reg_sel;
        e.wdat = ex.jump_wdat;
      end
      SrcLoad: begin
        e.rd   = ex.load_reg_sel;
        e.wdat = ex.load_wdat;
      end
      default: begin
        e.rd   = ex.alu_reg_sel;
        e.wdat = ex.alu_wdat;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/wbq_compact.sv
// Combinational 3-input compactor for the writeback queue.
// Packs the live results (done and not x0) into consecutive write slots in the order
// jump, load, alu.
// Ports:
//   res_valid  in  [2:0] live flags, bit 0 = jump, bit 1 = load, bit 2 = alu
//   slot_en    out [2:0] thermometer write enable for slots tail, tail+1, tail+2
//   slot_src   out [5:0] per-slot source index, slot k in bits [2k+1:2k]
//   n_in       out [1:0] number of live results
module wbq_compact
  import scalar_wb_queue_pkg::*;
(
  input  logic [2:0] res_valid,
  output logic [2:0] slot_en,
  output logic [5:0] slot_src,
  output logic [1:0] n_in
);

  logic [1:0] s0, s1, s2;

  always_comb begin
    s0 = 2'(SrcJump);
    s1 = 2'(SrcJump);
    s2 = 2'(SrcJump);
    unique case (res_valid)
      3'b000: ;
      3'b001: s0 = 2'(SrcJump);
      3'b010: s0 = 2'(SrcLoad);
      3'b011: begin s0 = 2'(SrcJump); s1 = 2'(SrcLoad); end
      3'b100: s0 = 2'(SrcAlu);
      3'b101: begin s0 = 2'(SrcJump); s1 = 2'(SrcAlu); end
      3'b110: begin s0 = 2'(SrcLoad); s1 = 2'(SrcAlu); end
      3'b111: begin s0 = 2'(SrcJump); s1 = 2'(SrcLoad); s2 = 2'(SrcAlu); end
    endcase
    slot_src = {s2, s1, s0};
  end

  always_comb begin
    n_in = 2'(res_valid[0]) + 2'(res_valid[1]) + 2'(res_valid[2]);
    unique case (n_in)
      2'd0:    slot_en = 3'b000;
      2'd1:    slot_en = 3'b001;
      2'd2:    slot_en = 3'b011;
      default: slot_en = 3'b111;
    endcase
  end

endmodule

// File: rtl/scalar_wb_queue.sv
// Scalar writeback queue: collects up to three scalar results per cycle (jump, load, alu),
// buffers them in order and retires at most one per cycle onto the register-file port.
// Speculative entries block at the head until resolved and are invalidated on mispredict.
// Optional feature macro: WB_BYPASS_EN (lone non-spec result into an empty queue is
// presented on the write port in the same cycle instead of being enqueued).
// Ports:
//   CLK, nRST     clock (rising edge), asynchronous active-low reset
//   ex_in         execute-stage results (execute_t)
//   bfu_resolved  outstanding speculation correct: clear spec everywhere
//   bfu_miss      mispredict: invalidate spec entries (wins over bfu_resolved)
//   wb_out        register-file write (wb_t)
//   s_rw_en/s_rw  copy of the write for clearing the dispatch RST entry
//   wbq_stall     fewer than three free entries; issue must hold completions
module scalar_wb_queue
  import scalar_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH
) (
  input  logic     CLK,
  input  logic     nRST,
  input  execute_t ex_in,
  input  logic     bfu_resolved,
  input  logic     bfu_miss,
  output wb_t      wb_out,
  output logic     s_rw_en,
  output regbits_t s_rw,
  output logic     wbq_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wbq_entry_t entries_q [DEPTH];
  wbq_entry_t entries_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, widx;
  logic [CW-1:0] count_q, count_d, free;

  logic [2:0] res_valid, slot_en, acc_en;
  logic [5:0] slot_src;
  logic [1:0] n_in, n_acc;
  logic       pop, head_live, bypass;
  wbq_entry_t head_e;

  // x0 results are filtered before compaction so they never occupy a slot.
  assign res_valid = {ex_in.alu_done  & (|ex_in.alu_reg_sel),
                      ex_in.load_done & (|ex_in.load_reg_sel),
                      ex_in.jump_done & (|ex_in.jump_reg_sel)};

  wbq_compact u_compact (
    .res_valid (res_valid),
    .slot_en   (slot_en),
    .slot_src  (slot_src),
    .n_in      (n_in)
  );

  assign head_e    = entries_q[head_q];
  assign head_live = (count_q != '0) && head_e.valid && !head_e.spec;
  // Squash bubbles (invalid heads) drain silently; a spec head blocks.
  assign pop       = (count_q != '0) && (!head_e.valid || !head_e.spec);
  assign free      = CW'(DEPTH) - count_q;
  assign wbq_stall = free < CW'(WBQ_MAX_IN);

`ifdef WB_BYPASS_EN
  assign bypass = (count_q == '0) && (n_in == 2'd1) && !ex_in.spec;
`else
  assign bypass = 1'b0;
`endif

  // Accepted slots: clip to free space so a stall violation never overwrites live entries.
  always_comb begin
    acc_en = slot_en;
    if (free == CW'(0)) begin
      acc_en = 3'b000;
    end else if (free == CW'(1)) begin
      acc_en = slot_en & 3'b001;
    end else if (free == CW'(2)) begin
      acc_en = slot_en & 3'b011;
    end
    if (bypass || (bfu_miss && ex_in.spec)) begin
      acc_en = 3'b000;
    end
    n_acc = 2'(acc_en[0]) + 2'(acc_en[1]) + 2'(acc_en[2]);
  end

  always_comb begin
    entries_d = entries_q;
    widx      = tail_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bfu_miss) begin
        if (entries_q[AW'(i)].spec) entries_d[AW'(i)].valid = 1'b0;
      end else if (bfu_resolved) begin
        entries_d[AW'(i)].spec = 1'b0;
      end
    end
    if (pop) entries_d[head_q].valid = 1'b0;
    for (int unsigned k = 0; k < WBQ_MAX_IN; k++) begin
      if (acc_en[k]) begin
        widx                  = tail_q + AW'(k);
        entries_d[widx]       = wbq_pick(ex_in, slot_src[2*k +: 2]);
        entries_d[widx].valid = 1'b1;
        entries_d[widx].spec  = ex_in.spec & ~bfu_resolved;
      end
    end
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + AW'(n_acc);
    count_d = count_q + CW'(n_acc) - CW'(pop);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[AW'(i)] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  // Write port comes straight off the head flops; zero whenever nothing retires.
  always_comb begin
    wb_out = '0;
    if (head_live) begin
      wb_out.reg_en  = 1'b1;
      wb_out.reg_sel = head_e.rd;
      wb_out.wdat    = head_e.wdat;
    end
`ifdef WB_BYPASS_EN
    if (bypass) begin
      wb_out.reg_en  = 1'b1;
      wb_out.reg_sel = wbq_pick(ex_in, slot_src[1:0]).rd;
      wb_out.wdat    = wbq_pick(ex_in, slot_src[1:0]).wdat;
    end
`endif
  end

  assign s_rw_en = wb_out.reg_en;
  assign s_rw    = wb_out.reg_sel;

endmodule

// File: tb/tb_scalar_wb_queue.sv
// Self-checking bench for scalar_wb_queue: directed scenarios followed by random traffic,
// all compared against an in-order queue model of the retire/speculation rules.
module tb_scalar_wb_queue;
  import scalar_wb_queue_pkg::*;

  localparam int DEPTH = 8;

  logic     CLK = 1'b0;
  logic     nRST;
  execute_t ex_in;
  logic     bfu_resolved, bfu_miss;
  wb_t      wb_out;
  logic     s_rw_en;
  regbits_t s_rw;
  logic     wbq_stall;

  always #5 CLK = ~CLK;

  scalar_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ex_in        (ex_in),
    .bfu_resolved (bfu_resolved),
    .bfu_miss     (bfu_miss),
    .wb_out       (wb_out),
    .s_rw_en      (s_rw_en),
    .s_rw         (s_rw),
    .wbq_stall    (wbq_stall)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit        valid;
    bit        spec;
    bit [4:0]  rd;
    bit [31:0] wdat;
  } ment_t;

  ment_t mq[$];

  task automatic idle();
    ex_in        = '0;
    bfu_resolved = 1'b0;
    bfu_miss     = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge with inputs driven.
  task automatic tick(input string tag);
    ment_t     arr[$];
    ment_t     m;
    bit        e_en, e_stall, byp, pop;
    bit [4:0]  e_sel;
    bit [31:0] e_wd;
    int        room;
    arr.delete();
    if (ex_in.jump_done && ex_in.jump_reg_sel != 0) begin
      m.valid = 1; m.spec = 0; m.rd = ex_in.jump_reg_sel; m.wdat = ex_in.jump_wdat;
      arr.push_back(m);
    end
    if (ex_in.load_done && ex_in.load_reg_sel != 0) begin
      m.valid = 1; m.spec = 0; m.rd = ex_in.load_reg_sel; m.wdat = ex_in.load_wdat;
      arr.push_back(m);
    end
    if (ex_in.alu_done && ex_in.alu_reg_sel != 0) begin
      m.valid = 1; m.spec = 0; m.rd = ex_in.alu_reg_sel; m.wdat = ex_in.alu_wdat;
      arr.push_back(m);
    end
    e_en = 0; e_sel = 0; e_wd = 0; byp = 0;
    if (mq.size() > 0 && mq[0].valid && !mq[0].spec) begin
      e_en = 1; e_sel = mq[0].rd; e_wd = mq[0].wdat;
    end
`ifdef WB_BYPASS_EN
    if (mq.size() == 0 && arr.size() == 1 && !ex_in.spec) begin
      byp = 1; e_en = 1; e_sel = arr[0].rd; e_wd = arr[0].wdat;
    end
`endif
    e_stall = (DEPTH - mq.size()) < 3;
    #1;
    check_eq({tag, "_ctl"}, 64'({wb_out.reg_en, s_rw_en, wbq_stall}),
             64'({e_en, e_en, e_stall}));
    if (e_en) begin
      check_eq({tag, "_wb"}, 64'({wb_out.reg_sel, wb_out.wdat, s_rw}), 64'({e_sel, e_wd, e_sel}));
    end
    check_eq({tag, "_count"}, 64'(dut.count_q), 64'(mq.size()));
    @(posedge CLK);
    pop = mq.size() > 0 && (!mq[0].valid || !mq[0].spec);
    if (byp || (bfu_miss && ex_in.spec)) arr.delete();
    room = DEPTH - mq.size();
    while (arr.size() > room) void'(arr.pop_back());
    if (bfu_miss) begin
      foreach (mq[i]) if (mq[i].spec) mq[i].valid = 0;
    end else if (bfu_resolved) begin
      foreach (mq[i]) mq[i].spec = 0;
    end
    if (pop) void'(mq.pop_front());
    foreach (arr[i]) begin
      arr[i].spec = ex_in.spec && !bfu_resolved && !bfu_miss;
      mq.push_back(arr[i]);
    end
    @(negedge CLK);
  endtask

  task automatic idle_ticks(input string tag, input int n);
    idle();
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic drive3(input bit jd, input bit [4:0] jr, input bit ld, input bit [4:0] lr,
                        input bit ad, input bit [4:0] ar, input bit sp);
    idle();
    ex_in.jump_done = jd; ex_in.jump_reg_sel = jr; ex_in.jump_wdat = 32'h1000_0000 | 32'(jr);
    ex_in.load_done = ld; ex_in.load_reg_sel = lr; ex_in.load_wdat = 32'h2000_0000 | 32'(lr);
    ex_in.alu_done  = ad; ex_in.alu_reg_sel  = ar; ex_in.alu_wdat  = 32'h3000_0000 | 32'(ar);
    ex_in.spec      = sp;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check_eq("reset", 64'({wb_out, s_rw_en, s_rw, wbq_stall}), 64'(0));
    @(negedge CLK);
    nRST = 1'b1;
    mq.delete();

    // Single ALU result rd=5.
    drive3(0, 0, 0, 0, 1, 5'd5, 0);
    ex_in.alu_wdat = 32'hDEAD_BEEF;
`ifdef WB_BYPASS_EN
    #1;
    check_eq("alu_bypass", 64'({wb_out.reg_en, wb_out.reg_sel, wb_out.wdat, s_rw_en, s_rw}),
             64'({1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5}));
    tick("alu");
    idle();
`else
    tick("alu");
    idle();
    #1;
    check_eq("alu_next", 64'({wb_out.reg_en, wb_out.reg_sel, wb_out.wdat, s_rw_en, s_rw}),
             64'({1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5}));
`endif
    tick("alu_idle");

    drive3(1, 5'd1, 1, 5'd2, 1, 5'd3, 0);
    tick("three");
    idle_ticks("three_drain", 4);

    drive3(0, 0, 1, 5'd4, 1, 5'd0, 0);
    tick("x0");
    idle_ticks("x0_drain", 2);

    drive3(0, 0, 0, 0, 1, 5'd7, 1);
    tick("spec_in");
    idle_ticks("spec_wait", 3);
    bfu_resolved = 1'b1;
    tick("resolve");
    idle_ticks("resolved", 2);

    drive3(0, 0, 0, 0, 1, 5'd8, 0);
    tick("ns8");
    drive3(0, 0, 0, 0, 1, 5'd9, 1);
    tick("sp9");
    idle();
    bfu_miss = 1'b1;
    tick("miss");
    idle_ticks("miss_drain", 3);

    drive3(1, 5'd10, 1, 5'd11, 1, 5'd12, 1);
    tick("fill_a");
    drive3(1, 5'd13, 1, 5'd14, 1, 5'd15, 1);
    tick("fill_b");
    idle_ticks("full", 2);
    bfu_resolved = 1'b1;
    tick("full_res");
    idle_ticks("full_drain", 8);

    // Random traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if (c == 1500) begin
        #2;
        nRST = 1'b0;
        #1;
        check_eq("mid_reset", 64'({wb_out, s_rw_en, s_rw, wbq_stall}), 64'(0));
        mq.delete();
        @(negedge CLK);
        nRST = 1'b1;
      end
      if ((DEPTH - mq.size()) >= 3) begin
        ex_in.jump_done    = ($urandom_range(0, 2) == 0);
        ex_in.load_done    = ($urandom_range(0, 2) == 0);
        ex_in.alu_done     = ($urandom_range(0, 1) == 0);
        ex_in.jump_reg_sel = 5'($urandom_range(0, 7));
        ex_in.load_reg_sel = 5'($urandom_range(0, 31));
        ex_in.alu_reg_sel  = 5'($urandom_range(0, 31));
        ex_in.jump_wdat    = $urandom;
        ex_in.load_wdat    = $urandom;
        ex_in.alu_wdat     = $urandom;
        ex_in.spec         = ($urandom_range(0, 3) == 0);
      end
      bfu_resolved = ($urandom_range(0, 4) == 0);
      bfu_miss     = ($urandom_range(0, 9) == 0);
      tick("rand");
    end
    idle_ticks("final", 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
